// File: rtl/rsa_result_scroller_pkg.sv
// Shared types and constants for the RSA result scroller.
// BITS is a macro so that the top and any wrappers agree on the result width.
`ifndef BITS
`define BITS 32
`endif

package rsa_result_scroller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    SHOW = 2'd2
  } state_t;

  localparam logic [4:0] PKG_BLANK_CODE = 5'h10;
  localparam int unsigned MAX_WINDOWS = 4;

  // Advance to the next 16-bit window, wrapping after the last one.
  function automatic logic [1:0] next_window(input logic [1:0] win,
                                             input int unsigned n_windows);
    if (n_windows <= 1 || win == 2'(n_windows - 1)) begin
      return 2'd0;
    end
    return win + 2'd1;
  endfunction

  function automatic logic [4:0] nibble_code(input logic [3:0] nibble);
    return {1'b0, nibble};
  endfunction

endpackage

// File: rtl/rsa_dwell_timer.sv
// Dwell counter for the result scroller: counts enabled cycles and emits a
// one-cycle wrap pulse at TICK_DIV-1; clear has priority over counting.
module rsa_dwell_timer #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_clear,
  output logic o_wrap
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign o_wrap    = i_en & ~i_clear & w_at_last;

  always_ff @(posedge clk) begin
    if (i_reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_at_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rsa_result_scroller.sv
// Captures the RSA result on DONE and scrolls it through 16-bit windows onto
// the four seven-segment digit codes, with busy/valid/window decimal points.
module rsa_result_scroller
  import rsa_result_scroller_pkg::*;
#(
  parameter int unsigned BITS       = `BITS,
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter logic [4:0]  BLANK_CODE = PKG_BLANK_CODE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] result_in,
  input  logic            done_in,
  input  logic            go_in,
  input  logic            hold_in,
  output logic [4:0]      dig3,
  output logic [4:0]      dig2,
  output logic [4:0]      dig1,
  output logic [4:0]      dig0,
  output logic [3:0]      decpts,
  output logic [1:0]      win_idx
);

  localparam int unsigned N_WIN = BITS / 16;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_done_q;
  logic            r_go_q;
  logic [BITS-1:0] r_capture;
  logic [1:0]      r_win_idx;

  logic            w_done_rise;
  logic            w_go_rise;
  logic            w_go_fall;
  logic            w_timer_en;
  logic            w_wrap;
  logic [15:0]     w_windows [MAX_WINDOWS];
  logic [15:0]     w_cur_window;

  assign w_done_rise = done_in & ~r_done_q;
  assign w_go_rise   = go_in & ~r_go_q;
  assign w_go_fall   = ~go_in & r_go_q;
  assign w_timer_en  = (r_state == SHOW) & ~hold_in;

  rsa_dwell_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_dwell_timer (
    .clk     (clk),
    .i_reset (reset),
    .i_en    (w_timer_en),
    .i_clear (w_done_rise),
    .o_wrap  (w_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_done_rise) begin
      w_state_next = SHOW;
    end else begin
      unique case (r_state)
        IDLE:    if (w_go_rise) w_state_next = BUSY;
        BUSY:    if (w_go_fall) w_state_next = IDLE;
        SHOW:    if (w_go_rise) w_state_next = BUSY;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Edge detectors track the inputs during reset so a level already high
  // when reset releases is not mistaken for a fresh edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done_q  <= done_in;
      r_go_q    <= go_in;
      r_capture <= '0;
      r_win_idx <= 2'd0;
    end else begin
      r_done_q <= done_in;
      r_go_q   <= go_in;
      if (w_done_rise) begin
        r_capture <= result_in;
        r_win_idx <= 2'd0;
      end else if (w_wrap) begin
        r_win_idx <= next_window(r_win_idx, N_WIN);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_WINDOWS; gi++) begin : g_window
      if (gi < N_WIN) begin : g_used
        assign w_windows[gi] = r_capture[16*gi +: 16];
      end else begin : g_unused
        assign w_windows[gi] = 16'h0000;
      end
    end
  endgenerate

  assign w_cur_window = w_windows[r_win_idx];
  assign win_idx      = r_win_idx;

  always_comb begin
    dig3   = BLANK_CODE;
    dig2   = BLANK_CODE;
    dig1   = BLANK_CODE;
    dig0   = BLANK_CODE;
    decpts = 4'b0000;
    unique case (r_state)
      SHOW: begin
        dig3   = nibble_code(w_cur_window[15:12]);
        dig2   = nibble_code(w_cur_window[11:8]);
        dig1   = nibble_code(w_cur_window[7:4]);
        dig0   = nibble_code(w_cur_window[3:0]);
        decpts = {r_win_idx, 1'b0, 1'b1};
      end
      BUSY:    decpts = 4'b0010;
      default: decpts = 4'b0000;
    endcase
  end

endmodule

// File: tb/tb_rsa_result_scroller.sv
// Self-checking bench for rsa_result_scroller (BITS=32, TICK_DIV=4): a
// behavioural model checked every cycle plus hand-computed display points.
module tb_rsa_result_scroller;

  localparam int TD = 4;
  localparam int NW = 2;
  localparam int M_IDLE = 0, M_BUSY = 1, M_SHOW = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] result_in;
  logic        done_in, go_in, hold_in;
  logic [4:0]  dig3, dig2, dig1, dig0;
  logic [3:0]  decpts;
  logic [1:0]  win_idx;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  rsa_result_scroller #(
    .BITS       (32),
    .TICK_DIV   (TD),
    .BLANK_CODE (5'h10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .result_in (result_in),
    .done_in   (done_in),
    .go_in     (go_in),
    .hold_in   (hold_in),
    .dig3      (dig3),
    .dig2      (dig2),
    .dig1      (dig1),
    .dig0      (dig0),
    .decpts    (decpts),
    .win_idx   (win_idx)
  );

  always #5 clk = ~clk;

  // Model: display mode, held value, window and dwell position.
  int          m_mode, m_win, m_cnt;
  logic [31:0] m_val;
  bit          m_dq, m_gq;

  always @(posedge clk) begin : model
    bit dr, gr, gf, tk, wr;
    int n_mode, n_win, n_cnt;
    logic [31:0] n_val;
    if (reset) begin
      m_mode <= M_IDLE; m_val <= 0; m_win <= 0; m_cnt <= 0;
      m_dq <= done_in; m_gq <= go_in;
    end else begin
      dr = done_in && !m_dq;
      gr = go_in && !m_gq;
      gf = !go_in && m_gq;
      n_mode = m_mode; n_val = m_val; n_win = m_win; n_cnt = m_cnt;
      tk = (m_mode == M_SHOW) && !hold_in;
      wr = tk && (m_cnt == TD - 1);
      if (dr) begin
        n_val = result_in; n_win = 0; n_cnt = 0; n_mode = M_SHOW;
      end else begin
        if (tk) n_cnt = wr ? 0 : m_cnt + 1;
        if (wr) n_win = (m_win + 1) % NW;
        if (m_mode == M_IDLE && gr) n_mode = M_BUSY;
        else if (m_mode == M_BUSY && gf) n_mode = M_IDLE;
        else if (m_mode == M_SHOW && gr) n_mode = M_BUSY;
      end
      m_mode <= n_mode; m_val <= n_val; m_win <= n_win; m_cnt <= n_cnt;
      m_dq <= done_in; m_gq <= go_in;
    end
  end

  function automatic logic [19:0] hexd(input logic [15:0] v);
    return {1'b0, v[15:12], 1'b0, v[11:8], 1'b0, v[7:4], 1'b0, v[3:0]};
  endfunction

  always @(negedge clk) begin : compare
    logic [19:0] e_dig;
    logic [3:0]  e_dp;
    logic [15:0] w;
    if (chk_en) begin
      w = 16'((m_val >> (16 * m_win)) & 32'hFFFF);
      if (m_mode == M_SHOW) begin
        e_dig = hexd(w);
        e_dp  = {2'(m_win), 2'b01};
      end else begin
        e_dig = {4{5'h10}};
        e_dp  = (m_mode == M_BUSY) ? 4'b0010 : 4'b0000;
      end
      checks++;
      if ({dig3, dig2, dig1, dig0} !== e_dig || decpts !== e_dp || win_idx !== 2'(m_win)) begin
        failures++;
        $display("FAIL cycle t=%0t dig=%h dp=%b win=%0d required dig=%h dp=%b win=%0d",
                 $time, {dig3, dig2, dig1, dig0}, decpts, win_idx, e_dig, e_dp, m_win);
      end
    end
  end

  task automatic lit(input string name, input logic [19:0] e_dig,
                     input logic [3:0] e_dp, input logic [1:0] e_win);
    checks++;
    if ({dig3, dig2, dig1, dig0} !== e_dig || decpts !== e_dp || win_idx !== e_win) begin
      failures++;
      $display("FAIL %s dig=%h dp=%b win=%0d required dig=%h dp=%b win=%0d",
               name, {dig3, dig2, dig1, dig0}, decpts, win_idx, e_dig, e_dp, e_win);
    end
    $display("check %s dig=%h dp=%b win=%0d", name, {dig3, dig2, dig1, dig0}, decpts, win_idx);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [19:0] BLANK4 = {4{5'h10}};

  initial begin
    reset = 1'b1; done_in = 1'b0; go_in = 1'b0; hold_in = 1'b0; result_in = '0;
    tick(1);
    chk_en = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(10);
    lit("reset_idle", BLANK4, 4'b0000, 2'd0);

    result_in = 32'hDEAD_BEEF; done_in = 1'b1;
    tick(1);
    lit("capture_w0", hexd(16'hBEEF), 4'b0001, 2'd0);
    done_in = 1'b0;
    tick(3);
    lit("dwell_w0_end", hexd(16'hBEEF), 4'b0001, 2'd0);
    tick(1);
    lit("scroll_w1", hexd(16'hDEAD), 4'b0101, 2'd1);
    tick(4);
    lit("scroll_back_w0", hexd(16'hBEEF), 4'b0001, 2'd0);

    tick(5);
    hold_in = 1'b1;
    tick(20);
    lit("hold_frozen", hexd(16'hDEAD), 4'b0101, 2'd1);
    hold_in = 1'b0;
    tick(2);
    lit("hold_resume", hexd(16'hDEAD), 4'b0101, 2'd1);
    tick(1);
    lit("hold_release_wrap", hexd(16'hBEEF), 4'b0001, 2'd0);

    go_in = 1'b1;
    tick(1);
    lit("go_busy", BLANK4, 4'b0010, 2'd0);
    result_in = 32'h0000_1234; done_in = 1'b1;
    tick(1);
    lit("busy_capture", hexd(16'h1234), 4'b0001, 2'd0);
    done_in = 1'b0; go_in = 1'b0;
    tick(1);

    result_in = 32'hCAFE_F00D; done_in = 1'b1; go_in = 1'b1;
    tick(1);
    lit("done_go_same", hexd(16'hF00D), 4'b0001, 2'd0);
    done_in = 1'b0; go_in = 1'b0;
    tick(3);
    result_in = 32'h1234_5678; done_in = 1'b1;
    tick(1);
    lit("done_on_wrap", hexd(16'h5678), 4'b0001, 2'd0);
    done_in = 1'b0;
    tick(5);
    lit("mid_scroll", hexd(16'h1234), 4'b0101, 2'd1);

    result_in = 32'hAAAA_5555; done_in = 1'b1; reset = 1'b1;
    tick(1);
    lit("reset_mid_scroll", BLANK4, 4'b0000, 2'd0);
    tick(1);
    reset = 1'b0;
    tick(3);
    lit("no_recapture", BLANK4, 4'b0000, 2'd0);
    done_in = 1'b0;
    tick(1);
    done_in = 1'b1;
    tick(1);
    lit("recapture", hexd(16'h5555), 4'b0001, 2'd0);
    tick(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
